// File: rtl/cmp_rr_scheduler_pkg.sv
// Shared types and defaults for the round-robin comparator scheduler.
// The state encoding is fixed so that waveform viewers and other tools all decode it the same way.
package cmp_sched_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_rr_scheduler_if.sv
// Requester-side bundle of the comparator scheduler: requests, operands and result/ack returns.
interface cmp_rr_scheduler_if
    import cmp_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int IDW   = $clog2(N_REQ)
);

    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] a_in;
    logic [N_REQ*W-1:0] b_in;
    logic [N_REQ-1:0]   sgn_in;
    logic [N_REQ-1:0]   ack;
    logic               res_gt;
    logic               res_eq;
    logic [IDW-1:0]     grant_id;
    logic               busy;

    modport master (
        output req, a_in, b_in, sgn_in,
        input  ack, res_gt, res_eq, grant_id, busy
    );

    modport slave (
        input  req, a_in, b_in, sgn_in,
        output ack, res_gt, res_eq, grant_id, busy
    );

endinterface

// File: rtl/cmp_rr_scheduler_cmp_unit.sv
// Combinational W-bit magnitude comparator; sgn selects two's-complement ordering.
module cmp_unit
    import cmp_sched_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sgn,
    output logic         gt,
    output logic         eq
);

    // Equality does not depend on the mode; only the ordering does.
    always_comb begin
        eq = (a == b);
        if (sgn) begin
            gt = ($signed(a) > $signed(b));
        end else begin
            gt = (a > b);
        end
    end

endmodule

// File: rtl/cmp_rr_scheduler.sv
// Round-robin scheduler that shares one comparator among N_REQ requesters.
// Each grant takes three cycles: latch operands, compare, respond with a one-hot ack.
module cmp_rr_scheduler
    import cmp_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    cmp_rr_scheduler_if.slave   bus
);

    localparam logic [N_REQ-1:0] ACK_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id_q;
    logic [IDW-1:0]   pick;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             sgn_q;
    logic [N_REQ-1:0] ack_q;
    logic             gt_q;
    logic             eq_q;
    logic             busy_q;
    logic             cmp_gt;
    logic             cmp_eq;
    logic [W-1:0]     a_arr [N_REQ];
    logic [W-1:0]     b_arr [N_REQ];

    // First requester at or after ptr, wrapping; returns ptr when nobody requests.
    function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDW-1:0]   ptr);
        logic [IDW-1:0] idx;
        logic           found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % N_REQ);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            a_arr[i] = bus.a_in[i*W +: W];
            b_arr[i] = bus.b_in[i*W +: W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pick    = rr_pick(bus.req, rr_ptr);
        case (state_q)
            IDLE:    if (|bus.req) state_d = CMP;
            CMP:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The ack is loaded on the RESP edge, so it is visible in the cycle after RESP
    // while grant_id and the held result still describe the finished operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr     <= '0;
            grant_id_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            ack_q      <= '0;
            gt_q       <= 1'b0;
            eq_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            ack_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        a_q        <= a_arr[pick];
                        b_q        <= b_arr[pick];
                        sgn_q      <= bus.sgn_in[pick];
                        grant_id_q <= pick;
                    end
                end
                CMP: begin
                    gt_q <= cmp_gt;
                    eq_q <= cmp_eq;
                end
                RESP: begin
                    ack_q  <= ACK_LSB << grant_id_q;
                    rr_ptr <= IDW'((int'(grant_id_q) + 1) % N_REQ);
                end
                default: ;
            endcase
        end
    end

    cmp_unit #(.W(W)) u_cmp (
        .a   (a_q),
        .b   (b_q),
        .sgn (sgn_q),
        .gt  (cmp_gt),
        .eq  (cmp_eq)
    );

    assign bus.ack      = ack_q;
    assign bus.res_gt   = gt_q;
    assign bus.res_eq   = eq_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_cmp_rr_scheduler.sv
// Self-checking bench for cmp_rr_scheduler: directed vectors, corner sequences and
// randomized traffic against a transaction-level round-robin/compare model.
module tb_cmp_rr_scheduler;

    localparam int N = 4;
    localparam int W = 4;

    typedef struct {
        int id;
        int a;
        int b;
        bit sgn;
        bit gt;
        bit eq;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nVectors = 0;
    int   nMiscompares = 0;

    always #5 clk = ~clk;

    cmp_rr_scheduler_if #(.N_REQ(N), .W(W)) bus();

    cmp_rr_scheduler #(.N_REQ(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference ordering from integer values: signed mode maps the upper half to negatives.
    function automatic void refCompare(input int a, input int b, input bit sgn,
                                       output bit gt, output bit eq);
        int sa = a;
        int sb = b;
        if (sgn) begin
            if (a >= (1 << (W-1))) sa = a - (1 << W);
            if (b >= (1 << (W-1))) sb = b - (1 << W);
        end
        gt = (sa > sb);
        eq = (a == b);
    endfunction

    task automatic checkResult(input string name, input int a, input int b, input bit sgn);
        bit gt;
        bit eq;
        refCompare(a, b, sgn, gt, eq);
        checkOutput({name, "_gt"}, 32'(bus.res_gt), 32'(gt));
        checkOutput({name, "_eq"}, 32'(bus.res_eq), 32'(eq));
    endtask

    task automatic applyStimulus(input int id, input int a, input int b, input bit sgn,
                                 input bit on);
        bus.a_in[id*W +: W] = W'(a);
        bus.b_in[id*W +: W] = W'(b);
        bus.sgn_in[id]      = sgn;
        bus.req[id]         = on;
    endtask

    task automatic waitAck(input int maxCycles, output logic [N-1:0] seen, output int cycles);
        seen   = '0;
        cycles = 0;
        while (cycles < maxCycles && seen == '0) begin
            @(negedge clk);
            cycles++;
            seen = bus.ack;
        end
        if (seen == '0) begin
            nVectors++;
            nMiscompares++;
            $display("[TB] FAIL ack_timeout: no ack within %0d cycles", maxCycles);
        end
    endtask

    vec_t           vecs [10];
    int             fa [N];
    int             fb [N];
    bit             fs [N];
    int             expOrder [4];
    bit             pend [N];
    int             ra [N];
    int             rb [N];
    bit             rs [N];

    initial begin
        logic [N-1:0] seen;
        logic [N-1:0] anyAck;
        int           cyc;
        int           prev;
        int           mptr;
        int           expIdx;
        int           npend;

        bus.req    = '0;
        bus.a_in   = '0;
        bus.b_in   = '0;
        bus.sgn_in = '0;

        vecs[0] = '{1, 'b1000, 'b0011, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1, 'b1000, 'b0011, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{0, 'b1111, 'b1111, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{2, 'b0111, 'b1000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{3, 'b0111, 'b1000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{0, 'b0000, 'b1111, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{2, 'b1110, 'b1111, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{3, 'b1111, 'b1110, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1, 'b0101, 'b0101, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{2, 'b0000, 'b0000, 1'b0, 1'b0, 1'b1};
        expOrder = '{1, 2, 3, 0};

        // Reset held with all requesting, then the first grant and its latency.
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            fa[i] = (i * 5 + 3) % 16;
            fb[i] = (i * 7) % 16;
            fs[i] = bit'(i % 2);
            applyStimulus(i, fa[i], fb[i], fs[i], 1'b1);
        end
        @(negedge clk);
        checkOutput("reset_ack", 32'(bus.ack), 0);
        checkOutput("reset_busy", 32'(bus.busy), 0);
        checkOutput("reset_grant_id", 32'(bus.grant_id), 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("lat_busy_cmp", 32'(bus.busy), 1);
        checkOutput("lat_grant_id", 32'(bus.grant_id), 0);
        checkOutput("lat_ack_cmp", 32'(bus.ack), 0);
        @(negedge clk);
        checkOutput("lat_ack_resp", 32'(bus.ack), 0);
        @(negedge clk);
        checkOutput("first_ack", 32'(bus.ack), 32'h1);
        checkOutput("busy_after_resp", 32'(bus.busy), 0);
        checkResult("first", fa[0], fb[0], fs[0]);
        prev = 0;
        bus.req[0] = 1'b0;

        // Fairness with every requester re-raising right after its ack.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("ack_width", 32'(bus.ack), 0);
            bus.req[prev] = 1'b1;
            waitAck(6, seen, cyc);
            checkOutput("fair_order", 32'(seen), 32'(1 << expOrder[k]));
            checkOutput("fair_spacing", 32'(cyc + 1), 3);
            checkResult("fair", fa[expOrder[k]], fb[expOrder[k]], fs[expOrder[k]]);
            prev = expOrder[k];
            bus.req[prev] = 1'b0;
        end
        @(negedge clk);
        bus.req = '0;
        repeat (5) @(negedge clk);

        // Directed compare vectors, one requester at a time.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            applyStimulus(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sgn, 1'b1);
            waitAck(6, seen, cyc);
            checkOutput($sformatf("vec%0d_ack", v), 32'(seen), 32'(1 << vecs[v].id));
            checkOutput($sformatf("vec%0d_lat", v), 32'(cyc), 3);
            checkOutput($sformatf("vec%0d_gt", v), 32'(bus.res_gt), 32'(vecs[v].gt));
            checkOutput($sformatf("vec%0d_eq", v), 32'(bus.res_eq), 32'(vecs[v].eq));
            bus.req[vecs[v].id] = 1'b0;
        end

        // Abort during CMP; the pointer must restart at 0 so requester 2 beats 3.
        @(negedge clk);
        applyStimulus(2, 'b0111, 'b0001, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("abort_busy_before", 32'(bus.busy), 1);
        checkOutput("abort_grant_before", 32'(bus.grant_id), 2);
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 0);
        checkOutput("abort_ack", 32'(bus.ack), 0);
        checkOutput("abort_grant_id", 32'(bus.grant_id), 0);
        applyStimulus(3, 'b0010, 'b0010, 1'b0, 1'b1);
        anyAck = '0;
        repeat (3) begin
            @(negedge clk);
            anyAck = anyAck | bus.ack;
        end
        checkOutput("abort_no_ack", 32'(anyAck), 0);
        reset = 1'b1;
        waitAck(6, seen, cyc);
        checkOutput("abort_resume_ack", 32'(seen), 32'h4);
        checkOutput("abort_resume_lat", 32'(cyc), 3);
        checkResult("abort_resume", 'b0111, 'b0001, 1'b0);
        bus.req[2] = 1'b0;
        waitAck(6, seen, cyc);
        checkOutput("abort_next_ack", 32'(seen), 32'h8);
        checkResult("abort_next", 'b0010, 'b0010, 1'b0);
        bus.req[3] = 1'b0;

        // Operand change after grant must not affect the result.
        @(negedge clk);
        applyStimulus(3, 'b0001, 'b0100, 1'b0, 1'b1);
        @(negedge clk);
        bus.a_in[3*W +: W] = 4'b1111;
        waitAck(6, seen, cyc);
        checkOutput("late_change_ack", 32'(seen), 32'h8);
        checkOutput("late_change_lat", 32'(cyc), 2);
        checkResult("late_change", 'b0001, 'b0100, 1'b0);
        bus.req[3] = 1'b0;

        // Randomized traffic against the transaction-level model.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mptr = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1 || i == N - 1) begin
                pend[i] = 1'b1;
                ra[i] = int'($urandom_range(0, 15));
                rb[i] = int'($urandom_range(0, 15));
                rs[i] = bit'($urandom_range(0, 1));
                applyStimulus(i, ra[i], rb[i], rs[i], 1'b1);
            end
        end
        for (int t = 0; t < 150; t++) begin
            waitAck(6, seen, cyc);
            if (seen == '0) break;
            expIdx = -1;
            for (int k = 0; k < N; k++) begin
                if (expIdx < 0 && pend[(mptr + k) % N]) expIdx = (mptr + k) % N;
            end
            checkOutput("rand_ack", 32'(seen), 32'(1 << expIdx));
            checkResult("rand", ra[expIdx], rb[expIdx], rs[expIdx]);
            pend[expIdx] = 1'b0;
            bus.req[expIdx] = 1'b0;
            mptr = (expIdx + 1) % N;
            npend = 0;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && i != expIdx && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ra[i] = int'($urandom_range(0, 15));
                    rb[i] = int'($urandom_range(0, 15));
                    rs[i] = bit'($urandom_range(0, 1));
                    applyStimulus(i, ra[i], rb[i], rs[i], 1'b1);
                end
                if (pend[i]) npend++;
            end
            if (npend == 0) begin
                prev = (expIdx + 1 + int'($urandom_range(0, N - 2))) % N;
                pend[prev] = 1'b1;
                ra[prev] = int'($urandom_range(0, 15));
                rb[prev] = int'($urandom_range(0, 15));
                rs[prev] = bit'($urandom_range(0, 1));
                applyStimulus(prev, ra[prev], rb[prev], rs[prev], 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
